// File: rtl/p2s_pkg.sv
// Shared types for the parallel-to-serial converter: FSM state encoding and frame length.
// No logic; P2S_PARITY_EN selects whether a trailing even-parity bit is part of the frame.
// Backpressure: not applicable.
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } p2s_state_t;

`ifdef P2S_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    // Serial bits per frame: data bits plus the optional parity bit.
    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/p2s_bitcnt.sv
// Counts accepted serial bits of a frame; done flags the final data bit (count == MAX-1).
// Latency: count updates on the edge after enable; clear has priority and acts the same edge.
// Backpressure: none, the caller gates enable with the bit handshake.
module p2s_bitcnt #(
    parameter int MAX = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       enable,
    output logic [$clog2(MAX+1)-1:0]   count,
    output logic                       done
);

    localparam int CW = $clog2(MAX + 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == CW'(MAX - 1));

endmodule

// File: rtl/par2ser.sv
// Parallel-to-serial converter; with P2S_PARITY_EN a trailing even-parity bit ends each frame.
// Latency: first serial bit valid the cycle after the word is accepted; back-to-back frames have no bubble.
// Backpressure: ser_ready_i low freezes the serial outputs; in_ready_o only in IDLE or on the final bit handshake.
module par2ser
    import p2s_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             ser_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    input  logic             ser_ready_i,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    p2s_state_t       state;
    p2s_state_t       state_nxt;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_ord;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             data_bit;
    logic             load;
    logic             advance;

    assign load    = in_valid_i && in_ready_o;
    assign advance = ser_valid_o && ser_ready_i;

    p2s_bitcnt #(.MAX(WIDTH)) u_bitcnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .enable (advance && (state == SHIFT)),
        .count  (cnt),
        .done   (cnt_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (advance && cnt_done) begin
`ifdef P2S_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = load ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
`ifdef P2S_PARITY_EN
                if (advance) state_nxt = load ? SHIFT : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The word is held whole; the bit counter selects the bit on the wire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= in_data_i;
        end
    end

`ifdef P2S_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^in_data_i;
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            word_ord[i] = (LSB_FIRST != 0) ? word_q[i] : word_q[WIDTH-1-i];
        end
        data_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CNT_W'(i)) data_bit = word_ord[i];
        end
    end

    always_comb begin
        ser_valid_o = (state != IDLE);
        busy_o      = (state != IDLE);
        ser_o       = 1'b0;
        ser_last_o  = 1'b0;
        case (state)
            SHIFT: begin
                ser_o = data_bit;
`ifndef P2S_PARITY_EN
                ser_last_o = cnt_done;
`endif
            end
            PARITY: begin
`ifdef P2S_PARITY_EN
                ser_o      = par_q;
                ser_last_o = 1'b1;
`endif
            end
            default: ;
        endcase
        in_ready_o = (state == IDLE) || (ser_valid_o && ser_ready_i && ser_last_o);
    end

endmodule

// File: tb/tb_par2ser.sv
// Directed scoreboard bench for par2ser: LSB-first and MSB-first instances driven in parallel.
// Expected bits are queued at acceptance and popped on each serial handshake.
module tb_par2ser;
    import p2s_pkg::*;

    localparam int W  = 4;
    localparam int NB = frame_len(W, PARITY_ON);

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         ser_ready = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_ready, ser, ser_valid, ser_last, busy;
    logic         in_ready_m, ser_m, ser_valid_m, ser_last_m, busy_m;

    int   tests = 0;
    int   fails = 0;
    int   popped = 0;
    int   run = 0;
    int   max_run = 0;
    exp_t exp_l[$];
    exp_t exp_m[$];

    par2ser #(.WIDTH(W), .LSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .ser_o(ser), .ser_valid_o(ser_valid), .ser_last_o(ser_last),
        .ser_ready_i(ser_ready), .busy_o(busy)
    );

    par2ser #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready_m),
        .in_data_i(in_data), .ser_o(ser_m), .ser_valid_o(ser_valid_m), .ser_last_o(ser_last_m),
        .ser_ready_i(ser_ready), .busy_o(busy_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.last = (i == NB - 1);
            e.b = w[i];
            exp_l.push_back(e);
            e.b = w[W-1-i];
            exp_m.push_back(e);
        end
        if (PARITY_ON) begin
            e.b = ^w;
            e.last = 1'b1;
            exp_l.push_back(e);
            exp_m.push_back(e);
        end
    endtask

    // Offer a word; returns one time unit after the accepting edge.
    task automatic send(input logic [W-1:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept_timeout", (n < 100), 1);
        if (n < 100) push_word(w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~w;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (exp_l.size() == 0 && exp_m.size() == 0) break;
        end
        check("drain_timeout", (n < 200), 1);
    endtask

    initial begin
        int p0;
        fork
            begin
                logic stall_prev, h_o, h_last, h_v;
                exp_t e;
                stall_prev = 1'b0;
                h_o = 1'b0; h_last = 1'b0; h_v = 1'b0;
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        stall_prev = 1'b0;
                        run = 0;
                    end else begin
                        if (stall_prev) begin
                            check("stall_hold_ser", ser, h_o);
                            check("stall_hold_last", ser_last, h_last);
                            check("stall_hold_valid", ser_valid, h_v);
                        end
                        run = ser_valid ? run + 1 : 0;
                        if (run > max_run) max_run = run;
                        if (ser_valid && ser_ready) begin
                            check("bit_expected_lsb", (exp_l.size() != 0), 1);
                            if (exp_l.size() != 0) begin
                                e = exp_l.pop_front();
                                check("ser_lsb", ser, e.b);
                                check("last_lsb", ser_last, e.last);
                            end
                            popped++;
                        end
                        if (ser_valid_m && ser_ready) begin
                            check("bit_expected_msb", (exp_m.size() != 0), 1);
                            if (exp_m.size() != 0) begin
                                e = exp_m.pop_front();
                                check("ser_msb", ser_m, e.b);
                                check("last_msb", ser_last_m, e.last);
                            end
                        end
                        stall_prev = ser_valid && !ser_ready;
                        h_o = ser; h_last = ser_last; h_v = ser_valid;
                    end
                end
            end
        join_none

        // Reset state
        #1;
        check("rst_valid", ser_valid, 0);
        check("rst_ser", ser, 0);
        check("rst_last", ser_last, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single word, latency and return to idle
        send(4'hA);
        check("first_bit_valid", ser_valid, 1);
        check("first_bit_lsb", ser, 0);
        check("first_bit_msb", ser_m, 1);
        check("busy_in_frame", busy, 1);
        drain();
        check("idle_valid", ser_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);

        // Back-to-back frames with no bubble
        max_run = 0;
        p0 = popped;
        send(4'hA);
        send(4'h3);
        drain();
        check("b2b_contiguous", max_run, 2 * NB);
        check("b2b_bits", popped - p0, 2 * NB);
        check("b2b_idle_valid", ser_valid, 0);

        // Downstream stall on the second bit
        p0 = popped;
        send(4'hA);
        @(posedge clk);
        #1;
        ser_ready = 1'b0;
        @(posedge clk);
        #1;
        check("stall_mid_ser", ser, 1);
        check("stall_mid_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        ser_ready = 1'b1;
        drain();
        check("stall_bits", popped - p0, NB);
        check("stall_idle_valid", ser_valid, 0);

        // Reset in mid-frame discards the frame
        send(4'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", ser_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ser", ser, 0);
        check("mid_rst_last", ser_last, 0);
        check("mid_rst_valid_m", ser_valid_m, 0);
        check("mid_rst_busy_m", busy_m, 0);
        exp_l.delete();
        exp_m.delete();
        in_valid = 1'b1;
        in_data  = 4'h5;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_in_ready", in_ready, 1);
            check("rst_hold_in_ready_m", in_ready_m, 1);
            check("rst_hold_valid", ser_valid, 0);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", ser_valid, 0);
        end
        send(4'hC);
        drain();
        check("recover_idle_valid", ser_valid, 0);

        // A few arbitrary words back to back
        for (int k = 0; k < 4; k++) begin
            send(W'($urandom));
        end
        drain();
        check("rand_idle_valid", ser_valid, 0);
        check("rand_queue_empty", exp_l.size() + exp_m.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/par2ser.md
PAR2SER -- requirements
Module: par2ser

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the parallel word width (>=2).
REQ-002 The module SHALL have parameter LSB_FIRST, default 1: 1 shifts bit 0 first, 0 shifts bit WIDTH-1 first.
REQ-003 The ports SHALL be as follows; clk is the clock and reset is asynchronous, active-high.
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in_valid_i  input  1  parallel word offered
- in_ready_o  output  1  parallel word can be accepted
- in_data_i  input  WIDTH  parallel word
- ser_o  output  1  serial bit
- ser_valid_o  output  1  ser_o carries a valid bit
- ser_last_o  output  1  final bit of the current frame
- ser_ready_i  input  1  downstream accepts ser_o
- busy_o  output  1  a frame is in progress

Function
REQ-004 A word SHALL be accepted on a rising clk edge where in_valid_i and in_ready_o are both 1.
REQ-005 The FSM SHALL have states IDLE and SHIFT, plus PARITY when the parity feature is compiled in.
REQ-006 in_ready_o SHALL be 1 in IDLE, and also in the cycle where ser_valid_o, ser_ready_i and ser_last_o are all 1; it SHALL be 0 otherwise (combinational path from ser_ready_i is permitted).
REQ-007 The first bit of an accepted word SHALL appear on ser_o with ser_valid_o=1 in the cycle after acceptance (latency 1).
REQ-008 A bit SHALL advance only on an edge where ser_valid_o and ser_ready_i are both 1; while ser_ready_i=0, ser_o, ser_valid_o and ser_last_o SHALL hold.
REQ-009 The bit counter SHALL be $clog2(WIDTH+1) bits wide, SHALL count accepted bits from 0 and SHALL clear on each load.
REQ-010 ser_last_o SHALL be 1 only on the final bit of a frame.
REQ-011 If a new word is accepted on the same edge as the last bit, the FSM SHALL stay in SHIFT and output the new word's first bit next cycle, with no bubble.
REQ-012 If no new word is accepted when the last bit completes, the FSM SHALL return to IDLE and ser_valid_o SHALL be 0 next cycle.
REQ-013 busy_o SHALL be 1 whenever the state is not IDLE.
REQ-014 in_data_i SHALL be sampled only on acceptance; later changes SHALL NOT affect the frame.

Reset
REQ-015 Asserting reset SHALL immediately set: state IDLE; ser_o, ser_valid_o, ser_last_o and busy_o to 0; shift register and counter to 0.
REQ-016 A frame interrupted by reset SHALL be discarded, with no residual bits after reset is released.
REQ-017 in_ready_o SHALL be 1 while in reset-forced IDLE, but no word SHALL be accepted while reset is asserted.

Configuration
REQ-018 With macro P2S_PARITY_EN defined, after the WIDTH data bits, state PARITY SHALL emit one even-parity bit (XOR of the word), and that bit SHALL carry ser_last_o; frames are WIDTH+1 bits.
REQ-019 Without P2S_PARITY_EN, frames SHALL be WIDTH bits, the last data bit SHALL carry ser_last_o, and no parity logic SHALL be synthesised.

Structure
REQ-020 Package p2s_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY) and a function giving frame length from WIDTH and the parity setting.
REQ-021 The bit counter SHALL be sub-module p2s_bitcnt (parameter MAX; inputs clear and enable; outputs count and done).

Verification
REQ-022 WIDTH=4, LSB_FIRST=1, ser_ready_i=1, send 4'hA -> ser_o 0,1,0,1 over 4 consecutive cycles, ser_last_o on the 4th only.
REQ-023 WIDTH=4, LSB_FIRST=0, send 4'hA -> ser_o 1,0,1,0.
REQ-024 Back-to-back 4'hA then 4'h3 with in_valid_i held -> 8 contiguous ser_valid_o cycles, ser_o 0,1,0,1,1,1,0,0, ser_last_o on cycles 4 and 8.
REQ-025 Send 4'hA with ser_ready_i=0 for 2 cycles after bit 1 -> ser_o holds 1 for 3 cycles, then 0,1 follow, 4 bits total.
REQ-026 P2S_PARITY_EN defined, send 4'h7 -> ser_o 1,1,1,0,1 with ser_last_o on the 5th bit.
REQ-027 Reset asserted after bit 2 of 4'hF -> ser_valid_o falls to 0 immediately and stays 0 until a new word is accepted.
